// File: rtl/uart_avl_mm_bridge.sv
// UART-to-Avalon-MM bridge: parses host command frames arriving from a UART
// RX core, performs one 32-bit read or write on Avalon-MM, and returns a
// status byte (plus read data) through a UART TX core.
module uart_avl_mm_bridge #(
  parameter int ADDR_WIDTH  = 32,
  parameter int RX_TIMEOUT  = 100000,
  parameter int BUS_TIMEOUT = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // UART RX side
  input  logic [7:0]            data_rx,
  input  logic                  data_rx_ready,
  output logic                  data_rx_ack,
  // UART TX side
  output logic [7:0]            data_tx,
  output logic                  data_tx_wr,
  input  logic                  data_tx_ack,
  // Avalon-MM initiator
  output logic [ADDR_WIDTH-1:0] avl_mm_addr,
  output logic                  avl_mm_read,
  input  logic [31:0]           avl_mm_readdata,
  input  logic [1:0]            avl_mm_response,
  output logic                  avl_mm_write,
  output logic [31:0]           avl_mm_writedata,
  output logic [3:0]            avl_mm_byteenable,
  input  logic                  avl_mm_waitrequest
);

  localparam logic [7:0] CMD_WR   = 8'h01;
  localparam logic [7:0] CMD_RD   = 8'h02;
  localparam logic [7:0] ERR_BYTE = 8'hEE;

  // Counter widths leave headroom so TIMEOUT-1 always fits.
  localparam int RXW  = $clog2(RX_TIMEOUT + 1);
  localparam int BUSW = $clog2(BUS_TIMEOUT + 1);

  localparam logic [RXW-1:0]  RX_LAST  = RXW'(RX_TIMEOUT - 1);
  localparam logic [BUSW-1:0] BUS_LAST = BUSW'(BUS_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RX_ADDR,
    S_RX_DATA,
    S_BUS,
    S_TX,
    S_TX_ERR
  } state_t;

  state_t          state_q,    state_d;
  logic            is_wr_q,    is_wr_d;     // frame is a write
  logic [1:0]      byte_cnt_q, byte_cnt_d;  // byte index within a 4-byte field
  logic [RXW-1:0]  idle_cnt_q, idle_cnt_d;  // cycles since last frame byte
  logic [31:0]     addr_q,     addr_d;
  logic [31:0]     wdata_q,    wdata_d;
  logic [31:0]     rdata_q,    rdata_d;     // doubles as the TX shift register
  logic [1:0]      resp_q,     resp_d;
  logic            rd_q,       rd_d;
  logic            wr_q,       wr_d;
  logic [BUSW-1:0] bus_cnt_q,  bus_cnt_d;   // consecutive stalled request cycles
  logic [7:0]      tx_data_q,  tx_data_d;
  logic            tx_wr_q,    tx_wr_d;
  logic [2:0]      tx_left_q,  tx_left_d;   // bytes still to send after the current one
  logic            drop_q,     drop_d;      // a byte was discarded during BUS/TX

  // The RX core is never back-pressured: every byte is consumed on arrival.
  assign data_rx_ack = data_rx_ready;

  assign data_tx           = tx_data_q;
  assign data_tx_wr        = tx_wr_q;
  assign avl_mm_addr       = addr_q[ADDR_WIDTH-1:0];
  assign avl_mm_read       = rd_q;
  assign avl_mm_write      = wr_q;
  assign avl_mm_writedata  = wdata_q;
  assign avl_mm_byteenable = (rd_q || wr_q) ? 4'hF : 4'h0;

  // Next-state and output decode for the frame/bus/response sequencer.
  always_comb begin
    // NOTE: every _d takes its hold value first; a path that skipped one would infer a latch.
    state_d    = state_q;
    is_wr_d    = is_wr_q;
    byte_cnt_d = byte_cnt_q;
    idle_cnt_d = idle_cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    resp_d     = resp_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    bus_cnt_d  = bus_cnt_q;
    tx_data_d  = tx_data_q;
    tx_wr_d    = tx_wr_q;
    tx_left_d  = tx_left_q;
    drop_d     = drop_q;

    // Bytes that arrive while the bridge is busy are swallowed but flagged.
    if (data_rx_ready && (state_q == S_BUS || state_q == S_TX || state_q == S_TX_ERR)) begin
      drop_d = 1'b1;
    end

    // Inter-byte timeout while collecting a frame; an arriving byte always wins.
    if (state_q == S_RX_ADDR || state_q == S_RX_DATA) begin
      if (data_rx_ready) begin
        idle_cnt_d = '0;
      end else if (idle_cnt_q == RX_LAST) begin
        idle_cnt_d = '0;
        state_d    = S_IDLE;
      end else begin
        idle_cnt_d = idle_cnt_q + 1'b1;
      end
    end

    case (state_q)
      S_IDLE: begin
        byte_cnt_d = '0;
        idle_cnt_d = '0;
        if (data_rx_ready) begin
          if (data_rx == CMD_WR || data_rx == CMD_RD) begin
            is_wr_d = (data_rx == CMD_WR);
            state_d = S_RX_ADDR;
          end else begin
            tx_data_d = ERR_BYTE;
            tx_wr_d   = 1'b1;
            state_d   = S_TX_ERR;
          end
        end
      end

      S_RX_ADDR: begin
        if (data_rx_ready) begin
          // LSB first: each new byte enters at the top and shifts down.
          addr_d     = {data_rx, addr_q[31:8]};
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            if (is_wr_q) begin
              state_d = S_RX_DATA;
            end else begin
              rd_d      = 1'b1;
              bus_cnt_d = '0;
              state_d   = S_BUS;
            end
          end
        end
      end

      S_RX_DATA: begin
        if (data_rx_ready) begin
          wdata_d    = {data_rx, wdata_q[31:8]};
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            wr_d      = 1'b1;
            bus_cnt_d = '0;
            state_d   = S_BUS;
          end
        end
      end

      S_BUS: begin
        // The request is registered on entry, so it is always high here.
        if (!avl_mm_waitrequest) begin
          if (!is_wr_q) begin
            rdata_d = avl_mm_readdata;
          end
          resp_d    = avl_mm_response;
          rd_d      = 1'b0;
          wr_d      = 1'b0;
          tx_data_d = {4'hA, 1'b0, drop_d, avl_mm_response};
          tx_wr_d   = 1'b1;
          tx_left_d = is_wr_q ? 3'd0 : 3'd4;
          state_d   = S_TX;
        end else if (bus_cnt_q == BUS_LAST) begin
          // Slave never answered: abandon with a SLVERR-coded status and zero data.
          rdata_d   = '0;
          resp_d    = 2'b10;
          rd_d      = 1'b0;
          wr_d      = 1'b0;
          tx_data_d = {4'hA, 1'b0, drop_d, 2'b10};
          tx_wr_d   = 1'b1;
          tx_left_d = is_wr_q ? 3'd0 : 3'd4;
          state_d   = S_TX;
        end else begin
          bus_cnt_d = bus_cnt_q + 1'b1;
        end
      end

      S_TX: begin
        if (data_tx_ack) begin
          if (tx_left_q != 3'd0) begin
            tx_data_d = rdata_q[7:0];
            rdata_d   = {8'h00, rdata_q[31:8]};
            tx_left_d = tx_left_q - 3'd1;
          end else begin
            tx_wr_d = 1'b0;
            state_d = S_IDLE;
          end
        end
      end

      S_TX_ERR: begin
        if (data_tx_ack) begin
          tx_wr_d = 1'b0;
          state_d = S_IDLE;
        end
      end

      default: begin
        rd_d    = 1'b0;
        wr_d    = 1'b0;
        tx_wr_d = 1'b0;
        state_d = S_IDLE;
      end
    endcase

    // The drop flag belongs to one frame; it is cleared on the way back to IDLE.
    if (state_d == S_IDLE) begin
      drop_d = 1'b0;
    end
  end

  // State and datapath registers; reset returns every output to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      is_wr_q    <= 1'b0;
      byte_cnt_q <= '0;
      idle_cnt_q <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      resp_q     <= '0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      bus_cnt_q  <= '0;
      tx_data_q  <= '0;
      tx_wr_q    <= 1'b0;
      tx_left_q  <= '0;
      drop_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from pre-edge values.
      state_q    <= state_d;
      is_wr_q    <= is_wr_d;
      byte_cnt_q <= byte_cnt_d;
      idle_cnt_q <= idle_cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      resp_q     <= resp_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      bus_cnt_q  <= bus_cnt_d;
      tx_data_q  <= tx_data_d;
      tx_wr_q    <= tx_wr_d;
      tx_left_q  <= tx_left_d;
      drop_q     <= drop_d;
    end
  end

endmodule

// File: tb/tb_uart_avl_mm_bridge.sv
// Directed bench for uart_avl_mm_bridge: a table of frames with hand-computed
// responses and bus expectations, plus sequences for timeouts, dropped bytes
// and reset in the middle of a bus access.
`timescale 1ns/1ps
module tb_uart_avl_mm_bridge;

  localparam int RX_TO  = 60;
  localparam int BUS_TO = 16;
  localparam int TX_LAT = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  data_rx = 8'h00;
  logic        data_rx_ready = 1'b0;
  logic        data_rx_ack;
  logic [7:0]  data_tx;
  logic        data_tx_wr;
  logic        data_tx_ack = 1'b0;
  logic [31:0] avl_mm_addr;
  logic        avl_mm_read;
  logic [31:0] avl_mm_readdata;
  logic [1:0]  avl_mm_response;
  logic        avl_mm_write;
  logic [31:0] avl_mm_writedata;
  logic [3:0]  avl_mm_byteenable;
  logic        avl_mm_waitrequest;

  always #5 clk = ~clk;

  uart_avl_mm_bridge #(
    .ADDR_WIDTH (32),
    .RX_TIMEOUT (RX_TO),
    .BUS_TIMEOUT(BUS_TO)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .data_rx           (data_rx),
    .data_rx_ready     (data_rx_ready),
    .data_rx_ack       (data_rx_ack),
    .data_tx           (data_tx),
    .data_tx_wr        (data_tx_wr),
    .data_tx_ack       (data_tx_ack),
    .avl_mm_addr       (avl_mm_addr),
    .avl_mm_read       (avl_mm_read),
    .avl_mm_readdata   (avl_mm_readdata),
    .avl_mm_response   (avl_mm_response),
    .avl_mm_write      (avl_mm_write),
    .avl_mm_writedata  (avl_mm_writedata),
    .avl_mm_byteenable (avl_mm_byteenable),
    .avl_mm_waitrequest(avl_mm_waitrequest)
  );

  // ---------------- slave model ----------------
  int          slv_wait  = 0;
  bit          slv_stuck = 1'b0;
  logic [31:0] slv_rdata = '0;
  logic [1:0]  slv_resp  = '0;
  int          req_cyc   = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) req_cyc <= 0;
    else if (avl_mm_read || avl_mm_write) req_cyc <= req_cyc + 1;
    else req_cyc <= 0;
  end

  assign avl_mm_waitrequest = (avl_mm_read || avl_mm_write) && (slv_stuck || req_cyc < slv_wait);
  assign avl_mm_readdata    = slv_rdata;
  assign avl_mm_response    = slv_resp;

  // Bus monitor, sampled mid-cycle.
  int          acc_cnt = 0, req_total = 0, addr_unstable = 0;
  logic [31:0] acc_addr, acc_wdata, held_addr, held_wdata;
  logic [3:0]  acc_be;
  logic        acc_wr, acc_rd;
  int          mon_cyc = 0;

  always @(negedge clk) begin
    if (rst_n && (avl_mm_read || avl_mm_write)) begin
      req_total++;
      if (mon_cyc > 0 && (avl_mm_addr !== held_addr || avl_mm_writedata !== held_wdata ||
                          avl_mm_byteenable !== 4'hF))
        addr_unstable++;
      held_addr  = avl_mm_addr;
      held_wdata = avl_mm_writedata;
      if (!avl_mm_waitrequest) begin
        acc_cnt++;
        acc_addr  = avl_mm_addr;
        acc_wdata = avl_mm_writedata;
        acc_be    = avl_mm_byteenable;
        acc_wr    = avl_mm_write;
        acc_rd    = avl_mm_read;
      end
      mon_cyc++;
    end else begin
      mon_cyc = 0;
    end
  end

  // ---------------- TX responder ----------------
  logic [7:0] tx_q[$];
  logic [7:0] tx_first;
  int         tx_hold = 0, tx_unstable = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      data_tx_ack = 1'b0;
      tx_hold     = 0;
    end else if (data_tx_ack) begin
      data_tx_ack = 1'b0;
    end else if (data_tx_wr) begin
      if (tx_hold == 0) tx_first = data_tx;
      else if (data_tx !== tx_first) tx_unstable++;
      if (tx_hold == TX_LAT) begin
        tx_q.push_back(data_tx);
        data_tx_ack = 1'b1;
        tx_hold     = 0;
      end else begin
        tx_hold++;
      end
    end
  end

  // ---------------- checking ----------------
  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    @(negedge clk);
    data_rx       = b;
    data_rx_ready = 1'b1;
    @(negedge clk);
    data_rx_ready = 1'b0;
    data_rx       = 8'h00;
    tick(gap);
  endtask

  task automatic clear_mon();
    acc_cnt       = 0;
    req_total     = 0;
    addr_unstable = 0;
    tx_unstable   = 0;
    tx_q.delete();
  endtask

  task automatic wait_tx(input int n, input int budget, input string name);
    int k = 0;
    while (tx_q.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (tx_q.size() < n) begin
      n_vec++;
      n_miss++;
      $display("FAIL %s_tx_timeout: got %0d bytes, expected %0d", name, tx_q.size(), n);
    end
    tick(6);
  endtask

  task automatic wait_req(input int budget, input string name);
    int k = 0;
    while (!(avl_mm_read || avl_mm_write) && k < budget) begin
      @(negedge clk);
      k++;
    end
    check({name, "_req_seen"}, 64'(avl_mm_read || avl_mm_write), 64'd1);
  endtask

  // Outputs concatenated: data_tx, data_tx_wr, read, write, byteenable, writedata.
  function automatic logic [63:0] out_vec();
    return 64'({data_tx, data_tx_wr, avl_mm_read, avl_mm_write, avl_mm_byteenable, avl_mm_writedata});
  endfunction

  typedef struct {
    int              nb;
    logic [8:0][7:0] frame;      // frame[0] is sent first
    int              wait_cyc;
    bit              stuck;
    logic [31:0]     rdata;
    logic [1:0]      resp;
    int              ntx;
    logic [4:0][7:0] exp_tx;     // exp_tx[0] is expected first
    int              exp_acc;
    int              exp_reqcyc;
    logic [31:0]     exp_addr;
    logic [31:0]     exp_wdata;
    bit              exp_write;
  } vec_t;

  function automatic vec_t mk(input int nb, input logic [71:0] frame, input int wait_cyc,
                              input bit stuck, input logic [31:0] rdata, input logic [1:0] resp,
                              input int ntx, input logic [39:0] exp_tx, input int exp_acc,
                              input int exp_reqcyc, input logic [31:0] exp_addr,
                              input logic [31:0] exp_wdata, input bit exp_write);
    vec_t v;
    v.nb = nb;           v.frame = frame;       v.wait_cyc = wait_cyc;
    v.stuck = stuck;     v.rdata = rdata;       v.resp = resp;
    v.ntx = ntx;         v.exp_tx = exp_tx;     v.exp_acc = exp_acc;
    v.exp_reqcyc = exp_reqcyc;                  v.exp_addr = exp_addr;
    v.exp_wdata = exp_wdata;                    v.exp_write = exp_write;
    return v;
  endfunction

  task automatic apply_vec(input string p, input vec_t v, input int gap);
    slv_wait  = v.wait_cyc;
    slv_stuck = v.stuck;
    slv_rdata = v.rdata;
    slv_resp  = v.resp;
    clear_mon();
    for (int i = 0; i < v.nb; i++) send_byte(v.frame[i], gap);
    wait_tx(v.ntx, 400, p);
    check({p, "_ntx"}, 64'(tx_q.size()), 64'(v.ntx));
    for (int i = 0; i < v.ntx; i++)
      if (i < tx_q.size()) check($sformatf("%s_tx%0d", p, i), 64'(tx_q[i]), 64'(v.exp_tx[i]));
    check({p, "_accesses"}, 64'(acc_cnt), 64'(v.exp_acc));
    check({p, "_req_cycles"}, 64'(req_total), 64'(v.exp_reqcyc));
    if (v.exp_reqcyc > 0) check({p, "_req_addr"}, 64'(held_addr), 64'(v.exp_addr));
    if (v.exp_acc > 0) begin
      check({p, "_acc_addr"}, 64'(acc_addr), 64'(v.exp_addr));
      check({p, "_acc_be"}, 64'(acc_be), 64'hF);
      check({p, "_acc_write"}, 64'(acc_wr), 64'(v.exp_write));
      check({p, "_acc_read"}, 64'(acc_rd), 64'(!v.exp_write));
      if (v.exp_write) check({p, "_acc_wdata"}, 64'(acc_wdata), 64'(v.exp_wdata));
    end
    check({p, "_bus_stable"}, 64'(addr_unstable), 64'd0);
    check({p, "_tx_stable"}, 64'(tx_unstable), 64'd0);
    check({p, "_idle_after"}, 64'({avl_mm_read, avl_mm_write, avl_mm_byteenable, data_tx_wr}), 64'd0);
  endtask

  vec_t vecs[9];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //        nb frame (last byte leftmost)        wait stk rdata         resp ntx exp_tx (last leftmost)  acc cyc addr           wdata          wr
    vecs[0] = mk(9, 72'h12_34_56_78_00_00_00_10_01, 0, 0, 32'h0,          2'b00, 1, 40'h00_00_00_00_A0, 1, 1,      32'h0000_0010, 32'h1234_5678, 1);
    vecs[1] = mk(5, 72'h00_00_00_00_00_00_00_14_02, 3, 0, 32'hDEAD_BEEF,  2'b00, 5, 40'hDE_AD_BE_EF_A0, 1, 4,      32'h0000_0014, 32'h0,         0);
    vecs[2] = mk(5, 72'h00_00_00_00_00_00_00_20_02, 0, 1, 32'hDEAD_BEEF,  2'b00, 5, 40'h00_00_00_00_A2, 0, BUS_TO, 32'h0000_0020, 32'h0,         0);
    vecs[3] = mk(9, 72'hDE_AD_BE_EF_80_00_00_04_01, 0, 1, 32'h0,          2'b00, 1, 40'h00_00_00_00_A2, 0, BUS_TO, 32'h8000_0004, 32'hDEAD_BEEF, 1);
    vecs[4] = mk(1, 72'h00_00_00_00_00_00_00_00_55, 0, 0, 32'h0,          2'b00, 1, 40'h00_00_00_00_EE, 0, 0,      32'h0,         32'h0,         0);
    vecs[5] = mk(5, 72'h00_00_00_00_7F_FF_FF_FC_02, 0, 0, 32'h0BAD_F00D,  2'b11, 5, 40'h0B_AD_F0_0D_A3, 1, 1,      32'h7FFF_FFFC, 32'h0,         0);
    vecs[6] = mk(9, 72'hA5_A5_5A_5A_FF_FF_FF_FC_01, 2, 0, 32'h0,          2'b01, 1, 40'h00_00_00_00_A1, 1, 3,      32'hFFFF_FFFC, 32'hA5A5_5A5A, 1);
    vecs[7] = mk(9, 72'h11_22_33_44_00_00_00_08_01, 0, 0, 32'h0,          2'b00, 1, 40'h00_00_00_00_A0, 1, 1,      32'h0000_0008, 32'h1122_3344, 1);
    vecs[8] = mk(5, 72'h00_00_00_00_00_00_00_30_02, 0, 0, 32'h1122_3344,  2'b00, 5, 40'h11_22_33_44_A0, 1, 1,      32'h0000_0030, 32'h0,         0);

    // Reset state.
    tick(3);
    check("reset_outputs", out_vec(), 64'd0);
    check("reset_addr", 64'(avl_mm_addr), 64'd0);
    check("reset_rx_ack", 64'(data_rx_ack), 64'd0);
    rst_n = 1'b1;
    tick(3);

    // Table: main function across frame types, stalls, bus timeouts, bad command.
    for (int i = 0; i < 7; i++) apply_vec($sformatf("v%0d", i), vecs[i], 2);

    // Frame cut after two address bytes: dropped silently by the RX timeout.
    slv_wait = 0; slv_stuck = 1'b0;
    clear_mon();
    send_byte(8'h02, 2);
    send_byte(8'hAA, 2);
    send_byte(8'hBB, 0);
    tick(RX_TO + 20);
    check("rxto_no_tx", 64'(tx_q.size()), 64'd0);
    check("rxto_no_bus", 64'(req_total), 64'd0);
    apply_vec("rxto_next", vecs[7], 2);
    // Inter-byte gaps just inside the timeout still form a valid frame.
    apply_vec("slow_frame", vecs[8], RX_TO - 10);

    // Bytes arriving during BUS and TX are acked, discarded and flagged.
    slv_wait = 6; slv_rdata = 32'hCAFE_F00D; slv_resp = 2'b00;
    clear_mon();
    send_byte(8'h02, 2);
    send_byte(8'h40, 2);
    send_byte(8'h00, 2);
    send_byte(8'h00, 2);
    send_byte(8'h00, 0);
    wait_req(20, "drop");
    @(negedge clk);
    data_rx = 8'h99; data_rx_ready = 1'b1;
    #1 check("drop_rx_ack", 64'(data_rx_ack), 64'd1);
    @(negedge clk);
    data_rx = 8'h00; data_rx_ready = 1'b0;
    for (int k = 0; k < 100 && tx_q.size() < 1; k++) @(negedge clk);
    send_byte(8'h77, 0);
    wait_tx(5, 200, "drop");
    check("drop_ntx", 64'(tx_q.size()), 64'd5);
    if (tx_q.size() == 5) begin
      check("drop_status", 64'(tx_q[0]), 64'hA4);
      check("drop_rdata", 64'({tx_q[4], tx_q[3], tx_q[2], tx_q[1]}), 64'hCAFE_F00D);
    end
    check("drop_accesses", 64'(acc_cnt), 64'd1);
    check("drop_req_cycles", 64'(req_total), 64'd7);
    // Drop flag must not leak into the next frame.
    slv_wait = 0;
    clear_mon();
    send_byte(8'h02, 2);
    for (int k = 0; k < 4; k++) send_byte(8'h40, 2);
    wait_tx(5, 200, "drop_next");
    if (tx_q.size() > 0) check("drop_next_status", 64'(tx_q[0]), 64'hA0);

    // Reset pulse while a write is stalled on the bus: nothing resumes afterwards.
    slv_stuck = 1'b1; slv_wait = 0;
    clear_mon();
    send_byte(8'h01, 2);
    send_byte(8'h50, 2);
    send_byte(8'h00, 2);
    send_byte(8'h00, 2);
    send_byte(8'h00, 2);
    send_byte(8'h04, 2);
    send_byte(8'h03, 2);
    send_byte(8'h02, 2);
    send_byte(8'h01, 0);
    wait_req(20, "rst_mid");
    tick(3);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_mid_outputs", out_vec(), 64'd0);
    check("rst_mid_addr", 64'(avl_mm_addr), 64'd0);
    tick(2);
    rst_n = 1'b1;
    slv_stuck = 1'b0;
    clear_mon();
    tick(40);
    check("rst_mid_no_bus", 64'(req_total), 64'd0);
    check("rst_mid_no_tx", 64'(tx_q.size()), 64'd0);
    check("rst_mid_idle", out_vec(), 64'd0);
    apply_vec("post_rst", vecs[0], 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
